// File: rtl/mem_request_ctrl_pkg.sv
// Shared types for the memory request sequencer.
// Optional perf counters are enabled with MEM_REQ_PERF_EN.
package mem_request_ctrl_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IFETCH = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } reqstate_t;

   localparam int REQ_WAIT_LIMIT_DEF = 256;

endpackage

// File: rtl/mem_request_ctrl_if.sv
// Control-unit / cache-side bundle of the request sequencer.
// MEM_REQ_PERF_EN adds the instr_cnt / stall_cnt outputs.
interface mem_request_ctrl_if;
`ifdef MEM_REQ_PERF_EN
   import mem_request_ctrl_pkg::*;
`endif

   logic ihit;
   logic dhit;
   logic dren_req;
   logic dwen_req;
   logic regwr_req;
   logic halt_req;
   logic iREN;
   logic dREN;
   logic dWEN;
   logic pc_en;
   logic rf_wen;
   logic halt;
   logic err;
`ifdef MEM_REQ_PERF_EN
   word_t instr_cnt;
   word_t stall_cnt;

   modport master (
      input  ihit, dhit, dren_req, dwen_req,
      input  regwr_req, halt_req,
      output iREN, dREN, dWEN, pc_en, rf_wen,
      output halt, err, instr_cnt, stall_cnt
   );

   modport slave (
      output ihit, dhit, dren_req, dwen_req,
      output regwr_req, halt_req,
      input  iREN, dREN, dWEN, pc_en, rf_wen,
      input  halt, err, instr_cnt, stall_cnt
   );
`else
   modport master (
      input  ihit, dhit, dren_req, dwen_req,
      input  regwr_req, halt_req,
      output iREN, dREN, dWEN, pc_en, rf_wen,
      output halt, err
   );

   modport slave (
      output ihit, dhit, dren_req, dwen_req,
      output regwr_req, halt_req,
      input  iREN, dREN, dWEN, pc_en, rf_wen,
      input  halt, err
   );
`endif

endinterface

// File: rtl/mem_request_ctrl_sat_counter.sv
// Up-counter with clear priority and optional saturation at limit.
// With SAT_EN=0 it simply wraps modulo 2^W.
module mem_request_ctrl_sat_counter #(
   parameter int W      = 16,
   parameter bit SAT_EN = 1'b1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic [W-1:0] cnt,
   output logic         sat
);

   assign sat = SAT_EN && (cnt == limit);

   // Clear wins over increment; a saturated count holds.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !sat) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_request_ctrl.sv
// Fetch/data-phase sequencer qualifying PC advance and RF writes.
// Define MEM_REQ_PERF_EN to add instruction and stall counters.
module mem_request_ctrl
   import mem_request_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = REQ_WAIT_LIMIT_DEF,
   parameter int CNT_W      = 16
) (
   input logic               CLK,
   input logic               RST,
   mem_request_ctrl_if.master bus
);

   reqstate_t        state;
   logic             ld_q;
   logic             st_q;
   logic             err_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             wait_sat;
   logic             wait_inc;
   logic             in_if;
   logic             in_dw;
   logic             in_ht;
   logic             ifire;
   logic             dfire;
   logic             mem_op;
   logic             pc_en;

   assign in_if  = (state == IFETCH);
   assign in_dw  = (state == DWAIT);
   assign in_ht  = (state == HALTED);
   assign ifire  = in_if & bus.ihit;
   assign dfire  = in_dw & bus.dhit;
   assign mem_op = bus.dren_req | bus.dwen_req;

   // Only an unanswered in-phase request counts; any hit or state
   // change restarts the wait.
   assign wait_inc = (in_if & ~bus.ihit) | (in_dw & ~bus.dhit);

   mem_request_ctrl_sat_counter #(
      .W      (CNT_W),
      .SAT_EN (1'b1)
   ) u_wait (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (~wait_inc),
      .inc   (wait_inc),
      .limit (CNT_W'(WAIT_LIMIT)),
      .cnt   (wait_cnt),
      .sat   (wait_sat)
   );

   // Phase sequencing; HALT outranks a memory decode on the same ihit.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IFETCH;
         ld_q  <= 1'b0;
         st_q  <= 1'b0;
      end else begin
         unique case (state)
            IFETCH: begin
               if (bus.ihit) begin
                  if (bus.halt_req) begin
                     state <= HALTED;
                  end else if (mem_op) begin
                     ld_q  <= bus.dren_req;
                     st_q  <= bus.dwen_req;
                     state <= DWAIT;
                  end
               end
            end
            DWAIT: begin
               if (bus.dhit) begin
                  ld_q  <= 1'b0;
                  st_q  <= 1'b0;
                  state <= IFETCH;
               end
            end
            HALTED: state <= HALTED;
            default: state <= IFETCH;
         endcase
      end
   end

   // Timeout is sticky until reset; requests keep going regardless.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         err_q <= 1'b0;
      end else if (wait_sat) begin
         err_q <= 1'b1;
      end
   end

   // Store wins an illegal load+store decode.
   assign pc_en = ~RST & ((ifire & ~bus.halt_req & ~mem_op) | dfire);

   assign bus.iREN   = ~RST & in_if;
   assign bus.dREN   = ~RST & in_dw & ld_q & ~st_q;
   assign bus.dWEN   = ~RST & in_dw & st_q;
   assign bus.pc_en  = pc_en;
   assign bus.rf_wen = pc_en & bus.regwr_req;
   assign bus.halt   = ~RST & in_ht;
   assign bus.err    = ~RST & (err_q | wait_sat);

`ifdef MEM_REQ_PERF_EN
   word_t instr_cnt;
   word_t stall_cnt;
   logic  instr_wrap;
   logic  stall_wrap;

   mem_request_ctrl_sat_counter #(
      .W      (32),
      .SAT_EN (1'b0)
   ) u_instr (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (1'b0),
      .inc   (pc_en | (ifire & bus.halt_req)),
      .limit ('0),
      .cnt   (instr_cnt),
      .sat   (instr_wrap)
   );

   mem_request_ctrl_sat_counter #(
      .W      (32),
      .SAT_EN (1'b0)
   ) u_stall (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (1'b0),
      .inc   (~in_ht & ~pc_en),
      .limit ('0),
      .cnt   (stall_cnt),
      .sat   (stall_wrap)
   );

   assign bus.instr_cnt = instr_cnt;
   assign bus.stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Bench for mem_request_ctrl: directed cases plus random instruction mix
// checked against an instruction-level model (LIMIT=4).
module tb_mem_request_ctrl;

   localparam int LIM = 4;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   always #5 CLK = ~CLK;

   mem_request_ctrl_if bus ();

   mem_request_ctrl #(
      .WAIT_LIMIT (LIM),
      .CNT_W      (16)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int          nchk = 0;
   int          errs = 0;
   int          waitc = 0;
   bit          errm = 1'b0;
   logic [31:0] ic = '0;
   logic [31:0] sc = '0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit ih, input bit dh, input bit dr,
                        input bit dw, input bit rw, input bit hr);
      bus.ihit      = ih;
      bus.dhit      = dh;
      bus.dren_req  = dr;
      bus.dwen_req  = dw;
      bus.regwr_req = rw;
      bus.halt_req  = hr;
   endtask

   // One clock: drive, check at negedge, advance the model past the edge.
   task automatic tick(input string tag,
                       input bit ih, input bit dh, input bit dr,
                       input bit dw, input bit rw, input bit hr,
                       input bit ei, input bit ed, input bit ew,
                       input bit epc, input bit erf, input bit eh,
                       input bit waiting);
      drive(ih, dh, dr, dw, rw, hr);
      @(negedge CLK);
      if (waitc == LIM) errm = 1'b1;
      chk({tag, ".iREN"},   32'(bus.iREN),   32'(ei));
      chk({tag, ".dREN"},   32'(bus.dREN),   32'(ed));
      chk({tag, ".dWEN"},   32'(bus.dWEN),   32'(ew));
      chk({tag, ".pc_en"},  32'(bus.pc_en),  32'(epc));
      chk({tag, ".rf_wen"}, 32'(bus.rf_wen), 32'(erf));
      chk({tag, ".halt"},   32'(bus.halt),   32'(eh));
      chk({tag, ".err"},    32'(bus.err),    32'(errm));
`ifdef MEM_REQ_PERF_EN
      chk({tag, ".icnt"}, bus.instr_cnt, ic);
      chk({tag, ".scnt"}, bus.stall_cnt, sc);
      if (!eh) begin
         if (epc) ic = ic + 1;
         else     sc = sc + 1;
      end
`endif
      @(posedge CLK);
      #1;
      if (waiting) waitc = (waitc < LIM) ? waitc + 1 : LIM;
      else         waitc = 0;
   endtask

   // Asynchronous reset between edges; outputs must drop at once.
   task automatic do_reset(input string tag);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      RST = 1'b1;
      #1;
      chk({tag, ".iREN"},   32'(bus.iREN),   0);
      chk({tag, ".dREN"},   32'(bus.dREN),   0);
      chk({tag, ".dWEN"},   32'(bus.dWEN),   0);
      chk({tag, ".pc_en"},  32'(bus.pc_en),  0);
      chk({tag, ".rf_wen"}, 32'(bus.rf_wen), 0);
      chk({tag, ".halt"},   32'(bus.halt),   0);
      chk({tag, ".err"},    32'(bus.err),    0);
`ifdef MEM_REQ_PERF_EN
      chk({tag, ".icnt"}, bus.instr_cnt, 0);
      chk({tag, ".scnt"}, bus.stall_cnt, 0);
`endif
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      RST   = 1'b0;
      waitc = 0;
      errm  = 1'b0;
      ic    = '0;
      sc    = '0;
   endtask

   // kind: 0 alu, 1 load, 2 store, 3 load+store, 4 halt
   task automatic run_instr(input int kind, input bit rw,
                            input int fd, input int dd);
      bit dr;
      bit dw;
      bit hr;
      dr = (kind == 1) || (kind == 3);
      dw = (kind == 2) || (kind == 3);
      hr = (kind == 4);
      for (int k = 0; k < fd; k++)
         tick("fetch", 1'b0, 1'($urandom), dr, dw, rw, hr,
              1, 0, 0, 0, 0, 0, 1);
      if (kind == 0) begin
         tick("alu", 1'b1, 1'($urandom), dr, dw, rw, hr,
              1, 0, 0, 1, rw, 0, 0);
      end else if (kind == 4) begin
         tick("hret", 1'b1, 1'($urandom), dr, dw, rw, hr,
              1, 0, 0, 0, 0, 0, 0);
         ic = ic + 1;
      end else begin
         tick("imem", 1'b1, 1'($urandom), dr, dw, rw, hr,
              1, 0, 0, 0, 0, 0, 0);
         for (int k = 0; k < dd; k++)
            tick("dwait", 1'($urandom), 1'b0, dr, dw, rw, hr,
                 0, dr & ~dw, dw, 0, 0, 0, 1);
         tick("dhit", 1'($urandom), 1'b1, dr, dw, rw, hr,
              0, dr & ~dw, dw, 1, rw, 0, 0);
      end
   endtask

   initial begin
      do_reset("rst0");

      for (int i = 0; i < 3; i++) run_instr(0, 1'b1, 0, 0);
`ifdef MEM_REQ_PERF_EN
      chk("icnt3", bus.instr_cnt, 3);
`endif

      run_instr(1, 1'b1, 0, 2);
      run_instr(3, 1'b0, 1, 1);

      for (int i = 0; i < 40; i++)
         run_instr(int'($urandom_range(3, 0)), 1'($urandom),
                   int'($urandom_range(3, 0)),
                   int'($urandom_range(3, 0)));

      run_instr(4, 1'b1, 1, 0);
      for (int i = 0; i < 10; i++)
         tick("halted", 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom),
              0, 0, 0, 0, 0, 1, 0);

      do_reset("rst1");

      tick("mid.imem", 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      tick("mid.dw", 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      chk("mid.dREN_pre", 32'(bus.dREN), 1);
      do_reset("rstmid");
      tick("post.alu", 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0);
      run_instr(2, 1'b0, 0, 1);

      for (int i = 0; i < 6; i++)
         tick("tmo", 0, 1'($urandom), 0, 0, 0, 0,
              1, 0, 0, 0, 0, 0, 1);
      chk("tmo.err_hold", 32'(bus.err), 1);
      chk("tmo.iREN", 32'(bus.iREN), 1);
      do_reset("rst2");
      tick("post.tmo", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", nchk, errs);
      $finish;
   end

endmodule

// File: doc/mem_request_ctrl.md
Name: mem_request_ctrl

Overview:
- Sequences the single-cycle datapath's memory traffic.
- Fetch phase: asserts instruction read and waits for ihit.
- Data phase, for a decoded load or store: holds the PC and waits for dhit.
- Qualifies PC advance and register-file write enable so state commits exactly once per instruction.
- Tracks halt; flags a memory request that never completes.
- Sits between control unit outputs and the datapath_cache_if request/hit signals.

Parameters:
- WAIT_LIMIT, 256: cycles a single ihit/dhit wait may last before err asserts; legal range 2..65535.
- CNT_W, 16: width of the internal wait counter; must hold WAIT_LIMIT.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ihit  in  1  instruction memory hit.
- dhit  in  1  data memory hit.
- dren_req  in  1  control unit: current instruction is a load.
- dwen_req  in  1  control unit: current instruction is a store.
- regwr_req  in  1  control unit: current instruction writes the register file.
- halt_req  in  1  control unit: current instruction is HALT.
- iREN  out  1  instruction memory read enable.
- dREN  out  1  data memory read enable.
- dWEN  out  1  data memory write enable.
- pc_en  out  1  single-cycle pulse: PC takes next value.
- rf_wen  out  1  single-cycle qualified register-file WEN.
- halt  out  1  sticky halt, to datapath_cache_if.halt.
- err  out  1  sticky: wait exceeded WAIT_LIMIT.

Behaviour:
- Reset value of every output is 0 while RST is high, regardless of state.
- RST asserting at any time immediately forces state to IFETCH and clears latched requests, wait_cnt and err.
- States: IFETCH, DWAIT, HALTED. Encoding is 2-bit, registered.
- IFETCH:
  - iREN=1, dREN=0, dWEN=0.
  - Without ihit: stay; wait_cnt++.
  - ihit & halt_req: go to HALTED; pc_en=0, rf_wen=0.
  - ihit & (dren_req|dwen_req): latch dren_req/dwen_req into ld_q/st_q; go to DWAIT; pc_en=0, rf_wen=0.
  - ihit, otherwise: pc_en=1, rf_wen=regwr_req; stay in IFETCH; wait_cnt cleared.
- DWAIT:
  - iREN=0, dREN=ld_q&~st_q, dWEN=st_q.
  - dren_req and dwen_req both set is an illegal decode; store wins.
  - Without dhit: stay; wait_cnt++.
  - On dhit: pc_en=1, rf_wen=regwr_req; go to IFETCH; wait_cnt cleared.
- HALTED: iREN=dREN=dWEN=pc_en=rf_wen=0; halt=1; exit only via RST.
- pc_en and rf_wen are Mealy (same cycle as the qualifying hit); request enables are Moore.
- Out-of-phase hits are ignored: dhit in IFETCH and ihit in DWAIT.
- ihit and dhit in the same cycle: only the hit matching the current state acts.
- Each state entry clears wait_cnt. wait_cnt saturates at WAIT_LIMIT and does not wrap.
- err sets the cycle wait_cnt reaches WAIT_LIMIT and stays set until RST. Requests keep asserting after err; no recovery action.
- Latency: a non-memory instruction commits in the ihit cycle. A load/store commits in the dhit cycle, at least 1 cycle after ihit.

Optional Feature:
- Macro: MEM_REQ_PERF_EN.
- Defined:
  - Adds outputs instr_cnt[31:0] and stall_cnt[31:0], both reset 0.
  - instr_cnt increments on each pc_en pulse, plus once on HALT retire.
  - stall_cnt increments every non-HALTED cycle without pc_en.
  - Both counters wrap modulo 2^32 and freeze in HALTED.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- cpu_types_pkg gains:
  - reqstate_t, a 2-bit enum {IFETCH, DWAIT, HALTED}.
  - parameter REQ_WAIT_LIMIT_DEF = 256.
- Counters use existing word_t.
- One sub-module is natural: sat_counter (width parameter, clr/inc/limit, saturate flag). Used for wait_cnt and reused for the perf counters with saturation disabled.

Test Plan:
- Non-memory stream: ihit high 3 cycles, regwr_req=1 -> pc_en=1 and rf_wen=1 each cycle, iREN=1, dREN=dWEN=0; instr_cnt=3 with MEM_REQ_PERF_EN.
- Load with 2-cycle dhit delay: dren_req=1, ihit at t0, dhit at t3 -> DWAIT t1..t3, dREN=1 t1..t3, pc_en=1 only at t3, rf_wen=1 only at t3.
- Store with dwen_req and dren_req both set -> dWEN=1, dREN=0 in DWAIT, rf_wen=0 with regwr_req=0.
- HALT: halt_req=1 with ihit -> next cycle halt=1 and all enables 0; further ihit/dhit for 10 cycles produce no change.
- Timeout: WAIT_LIMIT=4, ihit held low -> err=1 at cycle 4 after reset release, iREN still 1; then RST pulse -> err=0, iREN=0 during RST, 1 after.
- Reset mid-DWAIT: assert RST asynchronously between edges -> dREN drops immediately; after release state is IFETCH with ld_q=st_q=0.
